// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS stopwatch with run/pause, clear and adjust mode.
// Optional build macro BTN_DEBOUNCE_EN adds a DEB_CYCLES-long stability
// filter on the two pushbuttons. Without it the conditioned button level is
// the synchronizer output.
module stopwatch_counter #(
  parameter int CLK_HZ     = 100000000,
  parameter int ADJ_HZ     = 2,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_clr,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running
);

  localparam int ADJ_DIV = (CLK_HZ / ADJ_HZ > 0) ? (CLK_HZ / ADJ_HZ) : 1;
  localparam int SEC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int ADJ_W   = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
  localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(ADJ_DIV - 1);
  localparam logic [5:0]       FIELD_MAX = 6'd59;

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Bit order of the synchronizer bus: {sw_sel, sw_adj, btn_clr, btn_pause}
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic       adj_s;
  logic       sel_s;
  logic       adj_d;
  logic       adj_fall;

  logic [1:0] btn_level;
  logic [1:0] btn_prev;
  logic [1:0] btn_press;
  logic       pause_pulse;
  logic       clr_pulse;

  logic [SEC_W-1:0] sec_cnt;
  logic [ADJ_W-1:0] adj_cnt;
  logic             tick_1hz;
  logic             tick_adj;

  // Two-flop synchronizer for all asynchronous inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sw_sel, sw_adj, btn_clr, btn_pause};
      sync2 <= sync1;
    end
  end

  assign adj_s = sync2[2];
  assign sel_s = sync2[3];

`ifdef BTN_DEBOUNCE_EN
  localparam int DEB_N = (DEB_CYCLES > 1) ? DEB_CYCLES : 1;
  localparam int DEB_W = (DEB_N > 1) ? $clog2(DEB_N) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_N - 1);

  logic [DEB_W-1:0] deb_cnt [2];

  // Conditioned level follows the synchronized button only after it has
  // differed from the current level for DEB_CYCLES consecutive cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= '0;
      for (int unsigned i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != btn_level[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            btn_level[i] <= sync2[i];
            deb_cnt[i]   <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign btn_level = sync2[1:0];
`endif

  // Rising-edge detect on the conditioned buttons; one registered pulse per press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev  <= '0;
      btn_press <= '0;
    end else begin
      btn_prev  <= btn_level;
      btn_press <= btn_level & ~btn_prev;
    end
  end

  assign pause_pulse = btn_press[0];
  assign clr_pulse   = btn_press[1];

  // Delayed adjust switch, used to spot the return to normal counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) adj_d <= 1'b0;
    else     adj_d <= adj_s;
  end

  assign adj_fall = adj_d & ~adj_s;

  // Run/pause state register; reset lands in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Next-state: a pause pulse toggles between RUN and PAUSED
  always_comb begin
    state_next = state;
    if (pause_pulse) begin
      state_next = (state == RUN) ? PAUSED : RUN;
    end
  end

  // RUN encodes as 1, so the state flop itself is the registered output
  assign running = (state == RUN);

  // Terminal-count ticks; the 1 Hz tick is gated by the pre-toggle state so a
  // coincident pause still lets that second land
  always_comb begin
    tick_1hz = 1'b0;
    tick_adj = 1'b0;
    if ((state == RUN) && !adj_s && (sec_cnt == SEC_LAST)) tick_1hz = 1'b1;
    if (adj_s && (adj_cnt == ADJ_LAST))                    tick_adj = 1'b1;
  end

  // 1 Hz divider: advances only in RUN outside adjust mode, restarts on clear
  // and on leaving adjust mode so the next second is a full one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_cnt <= '0;
    end else if (clr_pulse || adj_fall) begin
      sec_cnt <= '0;
    end else if ((state == RUN) && !adj_s) begin
      sec_cnt <= tick_1hz ? '0 : sec_cnt + 1'b1;
    end
  end

  // Adjust divider: free-runs only while adjust mode is active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adj_cnt <= '0;
    end else if (clr_pulse || !adj_s) begin
      adj_cnt <= '0;
    end else begin
      adj_cnt <= tick_adj ? '0 : adj_cnt + 1'b1;
    end
  end

  // Time fields: clear beats any tick; normal ticks carry sec into min,
  // adjust ticks bump only the selected field
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min <= '0;
      sec <= '0;
    end else if (clr_pulse) begin
      min <= '0;
      sec <= '0;
    end else if (tick_1hz) begin
      if (sec >= FIELD_MAX) begin
        sec <= '0;
        min <= (min >= FIELD_MAX) ? 6'd0 : min + 6'd1;
      end else begin
        sec <= sec + 6'd1;
      end
    end else if (tick_adj) begin
      if (sel_s) sec <= (sec >= FIELD_MAX) ? 6'd0 : sec + 6'd1;
      else       min <= (min >= FIELD_MAX) ? 6'd0 : min + 6'd1;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter at CLK_HZ=10, ADJ_HZ=2, default build.
// Reference model tracks time as seconds-of-hour plus fractional-second cycle
// counts, with input latencies taken from the synchronizer/press timing.
module tb_stopwatch_counter;

  localparam int CLK_HZ  = 10;
  localparam int ADJ_HZ  = 2;
  localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_clr = 1'b0;
  logic       sw_adj = 1'b0;
  logic       sw_sel = 1'b0;
  logic [5:0] min;
  logic [5:0] sec;
  logic       running;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   m_min, m_sec, frac1, fraca;
  bit   m_run;
  logic [4:0] ph, ch, ah, sh;

  stopwatch_counter #(
    .CLK_HZ(CLK_HZ),
    .ADJ_HZ(ADJ_HZ),
    .DEB_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_pause(btn_pause),
    .btn_clr(btn_clr),
    .sw_adj(sw_adj),
    .sw_sel(sw_sel),
    .min(min),
    .sec(sec),
    .running(running)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_min = 0; m_sec = 0; frac1 = 0; fraca = 0; m_run = 1'b1;
    ph = '0; ch = '0; ah = '0; sh = '0;
  endtask

  // One rising edge of the reference: inputs reach the core two edges late,
  // a press takes effect on the fourth edge after the button rises
  task automatic model_edge();
    bit adj, fall, pz, cl, sel, t1, ta;
    int tot;
    if (rst) begin
      model_reset();
      return;
    end
    ph = {ph[3:0], btn_pause};
    ch = {ch[3:0], btn_clr};
    ah = {ah[3:0], sw_adj};
    sh = {sh[3:0], sw_sel};
    adj  = ah[2];
    fall = ah[3] & ~ah[2];
    sel  = sh[2];
    pz   = ph[3] & ~ph[4];
    cl   = ch[3] & ~ch[4];
    t1 = m_run && !adj && (frac1 == CLK_HZ - 1);
    ta = adj && (fraca == ADJ_DIV - 1);
    if (cl) begin
      m_min = 0; m_sec = 0;
    end else if (t1) begin
      tot = (m_min * 60 + m_sec + 1) % 3600;
      m_min = tot / 60;
      m_sec = tot % 60;
    end else if (ta) begin
      if (sel) m_sec = (m_sec + 1) % 60;
      else     m_min = (m_min + 1) % 60;
    end
    if (cl || fall)          frac1 = 0;
    else if (m_run && !adj)  frac1 = (frac1 + 1) % CLK_HZ;
    if (cl || !adj) fraca = 0;
    else            fraca = (fraca + 1) % ADJ_DIV;
    if (pz) m_run = !m_run;
  endtask

  task automatic check_model(input string tag);
    total++;
    assert (min === 6'(m_min)) else begin
      bad++; $error("FAIL %s min: got %0d want %0d", tag, min, m_min);
    end
    total++;
    assert (sec === 6'(m_sec)) else begin
      bad++; $error("FAIL %s sec: got %0d want %0d", tag, sec, m_sec);
    end
    total++;
    assert (running === m_run) else begin
      bad++; $error("FAIL %s running: got %0b want %0b", tag, running, m_run);
    end
    total++;
    assert (min <= 6'd59 && sec <= 6'd59) else begin
      bad++; $error("FAIL %s range: got %0d:%0d want <=59", tag, min, sec);
    end
  endtask

  task automatic check_const(input string tag, input int emin, input int esec, input bit erun);
    total++;
    assert (min === 6'(emin) && sec === 6'(esec) && running === erun) else begin
      bad++;
      $error("FAIL %s: got %0d:%0d run=%0b want %0d:%0d run=%0b",
             tag, min, sec, running, emin, esec, erun);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic bound_fail(input string tag);
    total++;
    bad++;
    $error("FAIL %s: timeout got no match want target value", tag);
  endtask

  initial begin
    int guard;
    model_reset();

    // Reset state
    #12;
    check_const("reset", 0, 0, 1'b1);
    steps(2, "reset_hold");
    #3 rst = 1'b0;

    // 600 cycles of running -> 01:00
    steps(600, "run600");
    check_const("run600_end", 1, 0, 1'b1);

    // Clear coincident with the 00:09 -> 00:10 tick
    #2 rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    steps(96, "pre_clr");
    btn_clr = 1'b1;
    steps(2, "clr_hi");
    btn_clr = 1'b0;
    steps(2, "clr_lo");
    check_const("clr_vs_tick", 0, 0, 1'b1);

    // Pause at 00:03, hold, resume
    steps(35, "to_3s");
    btn_pause = 1'b1;
    steps(2, "pause_hi");
    btn_pause = 1'b0;
    steps(50, "paused");
    check_const("pause_hold", 0, 3, 1'b0);
    btn_pause = 1'b1;
    steps(2, "resume_hi");
    btn_pause = 1'b0;
    steps(20, "resumed");

    // Adjust min to 59 with sw_sel=0
    sw_adj = 1'b1;
    sw_sel = 1'b0;
    guard = 0;
    while (m_min != 59 && guard < 2000) begin
      step("adj_min");
      guard++;
    end
    if (guard >= 2000) bound_fail("adj_min_bound");

    // Adjust sec to 58, then watch 59, 00, 01 with min untouched
    sw_sel = 1'b1;
    guard = 0;
    while (m_sec != 58 && guard < 2000) begin
      step("adj_sec");
      guard++;
    end
    if (guard >= 2000) bound_fail("adj_sec_bound");
    steps(15, "adj_wrap");
    check_const("adj_no_carry", 59, 1, m_run);
    guard = 0;
    while (m_sec != 59 && guard < 2000) begin
      step("adj_sec59");
      guard++;
    end
    if (guard >= 2000) bound_fail("adj_sec59_bound");

    // Leave adjust at 59:59; first second after exit is full, then wrap
    sw_adj = 1'b0;
    if (!m_run) begin
      btn_pause = 1'b1;
      steps(2, "rerun_hi");
      btn_pause = 1'b0;
    end else begin
      steps(2, "exit_adj");
    end
    guard = 0;
    while (!(m_min == 0 && m_sec == 0) && guard < 200) begin
      step("wrap");
      guard++;
    end
    if (guard >= 200) bound_fail("wrap_bound");
    check_const("wrap_0000", 0, 0, 1'b1);

    // Min field wraps 59 -> 00 in adjust with sw_sel=0
    sw_adj = 1'b1;
    sw_sel = 1'b0;
    guard = 0;
    while (m_min != 59 && guard < 2000) begin
      step("adj_min2");
      guard++;
    end
    steps(ADJ_DIV + 1, "adj_min_wrap");
    check_const("adj_min_wrap", 0, m_sec, m_run);

    // Async reset mid-adjust: outputs clear without a clock edge
    steps(7, "mid_adj");
    #2 rst = 1'b1;
    #1;
    check_const("async_rst", 0, 0, 1'b1);
    model_reset();
    sw_adj = 1'b0;
    steps(2, "rst_hold");
    #2 rst = 1'b0;
    steps(25, "post_rst");

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)  btn_pause = ~btn_pause;
      if ($urandom_range(0, 199) == 0) btn_clr   = ~btn_clr;
      if ($urandom_range(0, 149) == 0) sw_adj    = ~sw_adj;
      if ($urandom_range(0, 19) == 0)  sw_sel    = ~sw_sel;
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
